// File: rtl/dsram_axi_bridge.sv
// dsram_axi_bridge: single-beat AXI4 master serving the MEM-stage data SRAM port with stall and error reporting
module dsram_axi_bridge #(
  parameter logic [3:0]  AXI_ID    = 4'b0001,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE} state_t;
  state_t                state_q;
  logic [3:0]            wen_q;
  logic [31:0]           addr_q, wdata_q, rdata_q;
  logic [TIMEOUT_W-1:0]  wd_q;
  logic                  aw_done_q, w_done_q;
  logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                  rdata_valid_q, bus_err_q;
  logic                  busy, expired, aw_hs, w_hs;
  logic                  unused_resp_id;
  assign busy    = (state_q == RD_AR) | (state_q == RD_R) | (state_q == WR_AWW) | (state_q == WR_B);
  assign expired = busy & (&wd_q);
  assign aw_hs   = awvalid_q & awready;
  assign w_hs    = wvalid_q & wready;
  assign unused_resp_id = ^{rid, bid, rlast};
  assign arid    = AXI_ID;
  assign araddr  = {addr_q[31:2], 2'b00};
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign bus_err         = bus_err_q;
  assign stallreq = resetn & (((state_q == IDLE) & data_sram_en) | busy);
  // Single-lane stores use byte size, aligned halfword pairs use halfword, everything else word
  assign awsize = (wen_q == 4'b0001 || wen_q == 4'b0010 || wen_q == 4'b0100 || wen_q == 4'b1000) ? 3'd0 :
                  (wen_q == 4'b0011 || wen_q == 4'b1100) ? 3'd1 : 3'd2;
  // Transaction FSM: watchdog expiry overrides any handshake in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      wen_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      wd_q          <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      if (busy) wd_q <= wd_q + 1'b1;
      if (expired) begin
        state_q   <= DONE;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        bus_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (data_sram_en) begin
            wen_q     <= data_sram_wen;
            addr_q    <= data_sram_addr;
            wdata_q   <= data_sram_wdata;
            wd_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (data_sram_wen == 4'b0000) begin
              state_q   <= RD_AR;
              arvalid_q <= 1'b1;
            end else begin
              state_q   <= WR_AWW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
          RD_AR: if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
          RD_R: if (rvalid) begin
            rready_q      <= 1'b0;
            rdata_q       <= rdata;
            rdata_valid_q <= 1'b1;
            bus_err_q     <= |rresp;
            state_q       <= DONE;
          end
          WR_AWW: begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
              bready_q <= 1'b1;
              state_q  <= WR_B;
            end
          end
          WR_B: if (bvalid) begin
            bready_q  <= 1'b0;
            bus_err_q <= |bresp;
            state_q   <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
